// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NREQ producers, in bursts of up to BURST words.
// Define FWA_FIXED_PRIO_EN to replace round-robin with fixed lowest-index-first priority.
module fifo_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int FBITS = 8,
    parameter int BURST = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*FBITS-1:0] req_data,
    output logic [NREQ-1:0]       req_ack,
    output logic [NREQ-1:0]       grant,
    input  logic                  fifo_full,
    output logic                  fifo_wr,
    output logic [FBITS-1:0]      fifo_data,
    output logic                  busy
);

    localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(BURST) + 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]    state;
    logic [CW-1:0] burst_cnt;
    logic [LW-1:0] last_win;
    logic [LW-1:0] owner;
    logic [LW-1:0] win;
    logic          acc;
    logic          release_now;

    assign busy = (state == GRANT);

    always_comb begin
        owner = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) owner = LW'(i);
        end
    end

    // Scan in reverse priority order so the highest-priority requester is written last and wins.
    always_comb begin : pick
        int idx;
        idx = 0;
        win = '0;
`ifdef FWA_FIXED_PRIO_EN
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) win = LW'(i);
        end
`else
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(last_win) + k) % NREQ;
            if (req_valid[idx]) win = LW'(idx);
        end
`endif
    end

    assign acc         = busy & req_valid[owner] & ~fifo_full;
    assign release_now = busy & ((acc & (burst_cnt == CW'(BURST - 1))) | ~req_valid[owner]);

    assign fifo_wr   = acc;
    assign req_ack   = acc ? grant : '0;
    assign fifo_data = (grant != '0) ? req_data[int'(owner)*FBITS +: FBITS] : '0;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= '0;
            burst_cnt <= '0;
            last_win  <= LW'(NREQ - 1);
        end else if (state == IDLE) begin
            if (|req_valid) begin
                grant     <= NREQ'(1) << win;
                last_win  <= win;
                burst_cnt <= '0;
                state     <= GRANT;
            end
        end else begin
            if (acc) burst_cnt <= burst_cnt + 1'b1;
            if (release_now) begin
                grant <= '0;
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: a per-producer word model predicts every write and grant.
// Define FWA_FIXED_PRIO_EN for both files to exercise the fixed-priority build.
module tb_fifo_wr_arbiter;

    localparam int NREQ  = 4;
    localparam int FBITS = 8;
    localparam int BURST = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*FBITS-1:0] req_data;
    logic [NREQ-1:0]       req_ack;
    logic [NREQ-1:0]       grant;
    logic                  fifo_full;
    logic                  fifo_wr;
    logic [FBITS-1:0]      fifo_data;
    logic                  busy;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NREQ(NREQ), .FBITS(FBITS), .BURST(BURST)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ack(req_ack), .grant(grant), .fifo_full(fifo_full),
        .fifo_wr(fifo_wr), .fifo_data(fifo_data), .busy(busy)
    );

    typedef struct {
        int         src;
        logic [7:0] data;
    } wr_t;

    int  errors = 0;
    int  checks = 0;
    wr_t exp_q[$];
    logic [7:0] words[NREQ][$];
    logic [NREQ-1:0] grant_log[$];
    logic [NREQ-1:0] prev_grant;
    int  wr_cnt[NREQ];
    int  m_owner, m_cnt, m_last;
    bit  m_acc;
    int  occ;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pending();
        int n = 0;
        for (int i = 0; i < NREQ; i++) n += words[i].size();
        return n;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_cnt = 0;
        m_last = NREQ - 1;
        prev_grant = '0;
        grant_log.delete();
        for (int i = 0; i < NREQ; i++) begin
            words[i].delete();
            wr_cnt[i] = 0;
        end
    endtask

    task automatic load(input int i, input int n);
        for (int k = 0; k < n; k++) words[i].push_back(8'(8'h10 + i * 8'h10 + k));
    endtask

    // One clock: drive producers from their word queues, check grant/ack, predict the write.
    task automatic cycle(input logic [NREQ-1:0] en, input logic full_in);
        logic [NREQ-1:0] v;
        logic [NREQ-1:0] exp_grant;
        wr_t e;
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            v[i] = en[i] && (words[i].size() > 0);
            req_data[i*FBITS +: FBITS] = (words[i].size() > 0) ? words[i][0] : 8'h00;
        end
        req_valid = v;
        fifo_full = full_in;
        #1;
        exp_grant = '0;
        if (m_owner >= 0) exp_grant[m_owner] = 1'b1;
        check("grant", grant, exp_grant);
        check("busy", busy, m_owner >= 0);
        if (grant != '0 && prev_grant == '0) grant_log.push_back(grant);
        prev_grant = grant;
        m_acc = (m_owner >= 0) && v[m_owner] && !full_in;
        check("req_ack", req_ack, m_acc ? exp_grant : '0);
        if (m_owner >= 0) begin
            if (m_acc) begin
                e.src  = m_owner;
                e.data = words[m_owner].pop_front();
                exp_q.push_back(e);
                m_cnt++;
            end
            if ((m_acc && m_cnt == BURST) || !v[m_owner]) m_owner = -1;
        end else begin
            for (int k = 1; k <= NREQ && m_owner < 0; k++) begin
`ifdef FWA_FIXED_PRIO_EN
                int j = k - 1;
`else
                int j = (m_last + k) % NREQ;
`endif
                if (v[j]) begin
                    m_owner = j;
                    m_last = j;
                    m_cnt = 0;
                end
            end
        end
    endtask

    task automatic reset_now();
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_fifo_wr", fifo_wr, 0);
        req_valid = '0;
        fifo_full = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // Monitor: every FIFO write must match the oldest predicted write.
    always @(negedge clk) begin
        wr_t e;
        if (fifo_wr) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_unexpected: fifo_wr=1 data=%0h grant=%0h, no write expected", fifo_data, grant);
            end else begin
                e = exp_q.pop_front();
                check("wr_data", fifo_data, e.data);
                check("wr_src", grant, 32'(1) << e.src);
                wr_cnt[e.src]++;
            end
        end else if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL wr_missing: fifo_wr=0, expected word %0h from producer %0d", e.data, e.src);
        end
    end

    initial begin
        logic [NREQ-1:0] en;
        logic [NREQ-1:0] t2_exp[5];
        int n3;
        t2_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rst = 1'b1;
        req_valid = '0;
        req_data = '0;
        fifo_full = 1'b0;
        model_reset();
        #12;
        check("init_grant", grant, 0);
        check("init_busy", busy, 0);
        check("init_fifo_wr", fifo_wr, 0);
        rst = 1'b0;

        // Round robin with everyone requesting, then a reset in the middle of producer 1's burst.
        for (int i = 0; i < NREQ; i++) load(i, 8);
        repeat (28) cycle(4'b1111, 1'b0);
`ifndef FWA_FIXED_PRIO_EN
        check("t2_rounds", grant_log.size() >= 5, 1);
        for (int i = 0; i < 5 && i < grant_log.size(); i++) check("t2_order", grant_log[i], t2_exp[i]);
`endif
        check("t1_midburst_busy", busy, 1);
        reset_now();

        for (int i = 0; i < NREQ; i++) load(i, 4);
        repeat (3) cycle(4'b1111, 1'b0);
        check("t1_first_grant", grant, 4'b0001);
        reset_now();

        // Full stall after producer 2 has written two words.
        load(2, 4);
        repeat (3) cycle(4'b0100, 1'b0);
        repeat (5) cycle(4'b0100, 1'b1);
        repeat (4) cycle(4'b0100, 1'b0);
        check("t3_drained", words[2].size(), 0);
        check("t3_count", wr_cnt[2], 4);
        reset_now();

        // Early release: producer 1 drops valid after one word, producer 3 follows.
        load(1, 4);
        load(3, 4);
        cycle(4'b0010, 1'b0);
        cycle(4'b1010, 1'b0);
        repeat (4) cycle(4'b1000, 1'b0);
        check("t4_p1_words", wr_cnt[1], 1);
        check("t4_grant3", grant, 4'b1000);
        reset_now();

        // Random validity against a FIFO whose occupancy drives fifo_full.
        for (int i = 0; i < NREQ; i++) load(i, 8);
        occ = 0;
        repeat (300) begin
            for (int i = 0; i < NREQ; i++) en[i] = ($urandom_range(0, 3) != 0);
            cycle(en, occ >= 4);
            if (m_acc) occ++;
            if (occ > 0 && $urandom_range(0, 1) == 1) occ--;
        end
        for (int n = 0; n < 200 && pending() > 0; n++) cycle(4'b1111, 1'b0);
        repeat (2) cycle(4'b0000, 1'b0);
        check("t5_pending", pending(), 0);
        for (int i = 0; i < NREQ; i++) check("t5_count", wr_cnt[i], 8);

`ifdef FWA_FIXED_PRIO_EN
        reset_now();
        load(1, 24);
        load(3, 24);
        repeat (30) cycle(4'b1010, 1'b0);
        n3 = 0;
        foreach (grant_log[i]) if (grant_log[i] == 4'b1000) n3++;
        check("t6_p3_never", n3, 0);
        check("t6_p1_rounds", grant_log.size() >= 5, 1);
`else
        n3 = 0;
`endif
        @(negedge clk);
        #1;
        check("exp_q_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
